// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - fetch-stage branch resolver bus: ALU results, instr strobes, RAS status, target out
interface branch_unit_if #(
    parameter int ADDR_W = 10,
    parameter int IMM_W  = 6
);
    logic              equal;
    logic              less;
    logic              w_flag;
    logic [3:0]        flag_in;
    logic              branch_instr;
    logic              call_instr;
    logic              ret_instr;
    logic [IMM_W-1:0]  immediate;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] address;
    logic              branch;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_err;

    modport master (
        output equal, less, w_flag, flag_in,
        output branch_instr, call_instr, ret_instr, immediate, pc_next,
        input  address, branch, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  equal, less, w_flag, flag_in,
        input  branch_instr, call_instr, ret_instr, immediate, pc_next,
        output address, branch, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - conditional branch / call / return resolver with return-address stack
module branch_unit #(
    parameter int ADDR_W    = 10,
    parameter int IMM_W     = 6,
    parameter int IMM_SHIFT = 3,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    branch_unit_if.slave bus
);
    localparam int CNT_W  = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int WIDE_W = (IMM_W + IMM_SHIFT > ADDR_W) ? (IMM_W + IMM_SHIFT) : ADDR_W;

    logic [3:0]        r_flag;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic [ADDR_W-1:0] r_ras_mem [RAS_DEPTH];

    logic              w_empty;
    logic              w_full;
    logic              w_do_ret;
    logic              w_do_call;
    logic              w_do_br;
    logic              w_push;
    logic              w_pop;
    logic              w_overflow;
    logic              w_underflow;
    logic              w_cond;
    logic              w_taken;
    logic [WIDE_W-1:0] w_imm_wide;
    logic [ADDR_W-1:0] w_imm_tgt;
    logic [PTR_W-1:0]  w_top_idx;
    logic [PTR_W-1:0]  w_push_idx;
    logic [ADDR_W-1:0] w_top;
    logic [ADDR_W-1:0] w_address;
    logic              w_branch;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(RAS_DEPTH));

    // Priority ret > call > branch: a lower strobe has no effect at all when a higher one is up.
    assign w_do_ret  = bus.ret_instr;
    assign w_do_call = bus.call_instr & ~bus.ret_instr;
    assign w_do_br   = bus.branch_instr & ~bus.call_instr & ~bus.ret_instr;

    assign w_push      = w_do_call & ~w_full;
    assign w_pop       = w_do_ret & ~w_empty;
    assign w_overflow  = w_do_call & w_full;
    assign w_underflow = w_do_ret & w_empty;

    assign w_cond  = r_flag[0] | (r_flag[1] & bus.less) | (r_flag[2] & bus.equal);
    assign w_taken = w_cond ^ r_flag[3];

    // Widen before shifting so truncation to ADDR_W is the only place high bits are lost.
    assign w_imm_wide = WIDE_W'(bus.immediate) << IMM_SHIFT;
    assign w_imm_tgt  = w_imm_wide[ADDR_W-1:0];

    assign w_top_idx  = PTR_W'(r_count - CNT_W'(1));
    assign w_push_idx = PTR_W'(r_count);
    assign w_top      = w_empty ? '0 : r_ras_mem[w_top_idx];

    always_comb begin
        w_branch  = 1'b0;
        w_address = '0;
        if (w_do_ret) begin
            w_branch  = ~w_empty;
            w_address = w_top;
        end else if (w_do_call) begin
            w_branch  = 1'b1;
            w_address = w_imm_tgt;
        end else if (w_do_br) begin
            w_branch  = w_taken;
            w_address = w_imm_tgt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag <= 4'b0000;
        end else if (bus.w_flag) begin
            r_flag <= bus.flag_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_overflow || w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    // Entries are never cleared; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_ras_mem[w_push_idx] <= bus.pc_next;
        end
    end

    assign bus.address   = w_address;
    assign bus.branch    = w_branch;
    assign bus.ras_empty = w_empty;
    assign bus.ras_full  = w_full;
    assign bus.ras_err   = r_err;
endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed-vector bench for branch_unit
module tb_branch_unit;
    localparam int ADDR_W    = 10;
    localparam int IMM_W     = 6;
    localparam int IMM_SHIFT = 3;
    localparam int RAS_DEPTH = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    branch_unit_if #(.ADDR_W(ADDR_W), .IMM_W(IMM_W)) bif ();

    branch_unit #(
        .ADDR_W   (ADDR_W),
        .IMM_W    (IMM_W),
        .IMM_SHIFT(IMM_SHIFT),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bif.equal        = 1'b0;
        bif.less         = 1'b0;
        bif.w_flag       = 1'b0;
        bif.flag_in      = 4'b0000;
        bif.branch_instr = 1'b0;
        bif.call_instr   = 1'b0;
        bif.ret_instr    = 1'b0;
        bif.immediate    = '0;
        bif.pc_next      = '0;
    endtask

    // Advance one posedge and return at the following negedge, where inputs change.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        bif.w_flag  = 1'b1;
        bif.flag_in = f;
        tick();
        idle();
    endtask

    task automatic call(input logic [ADDR_W-1:0] pc);
        bif.call_instr = 1'b1;
        bif.pc_next    = pc;
        tick();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        @(negedge clk);
        #1;
        check_eq("rst_branch", bif.branch, 1'b0);
        check_eq("rst_address", bif.address, 10'd0);
        check_eq("rst_empty", bif.ras_empty, 1'b1);
        check_eq("rst_full", bif.ras_full, 1'b0);
        check_eq("rst_err", bif.ras_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // 1: equal-enabled branch, immediate 5 << 3 = 40
        load_flags(4'b0100);
        bif.branch_instr = 1'b1;
        bif.equal        = 1'b1;
        bif.immediate    = 6'd5;
        #1;
        check_eq("eq_taken", bif.branch, 1'b1);
        check_eq("eq_addr", bif.address, 10'd40);
        bif.equal = 1'b0;
        #1;
        check_eq("eq_not_taken", bif.branch, 1'b0);
        bif.immediate = 6'd63;
        #1;
        check_eq("imm_max_addr", bif.address, 10'd504);
        idle();

        // 2: less-enabled, inverted
        load_flags(4'b1010);
        bif.branch_instr = 1'b1;
        bif.less         = 1'b1;
        #1;
        check_eq("inv_less1", bif.branch, 1'b0);
        bif.less = 1'b0;
        #1;
        check_eq("inv_less0", bif.branch, 1'b1);
        idle();

        // 3: same-cycle flag write uses the old flags
        do_reset();
        bif.w_flag       = 1'b1;
        bif.flag_in      = 4'b0001;
        bif.branch_instr = 1'b1;
        #1;
        check_eq("old_flags", bif.branch, 1'b0);
        tick();
        bif.w_flag = 1'b0;
        #1;
        check_eq("new_flags", bif.branch, 1'b1);
        idle();

        // 4: call/call/ret/ret; second ret also has call+branch up (ret wins)
        do_reset();
        bif.call_instr = 1'b1;
        bif.immediate  = 6'd3;
        bif.pc_next    = 10'h011;
        #1;
        check_eq("call_branch", bif.branch, 1'b1);
        check_eq("call_addr", bif.address, 10'd24);
        tick();
        idle();
        call(10'h022);
        bif.ret_instr = 1'b1;
        #1;
        check_eq("ret1_branch", bif.branch, 1'b1);
        check_eq("ret1_addr", bif.address, 10'h022);
        tick();
        bif.ret_instr    = 1'b1;
        bif.call_instr   = 1'b1;
        bif.branch_instr = 1'b1;
        bif.immediate    = 6'd7;
        bif.pc_next      = 10'h3ff;
        #1;
        check_eq("ret2_branch", bif.branch, 1'b1);
        check_eq("ret2_addr", bif.address, 10'h011);
        tick();
        idle();
        #1;
        check_eq("ret_empty", bif.ras_empty, 1'b1);
        check_eq("ret_err", bif.ras_err, 1'b0);

        // 5: overflow then drain then underflow
        do_reset();
        for (int i = 0; i < RAS_DEPTH; i++) begin
            call(ADDR_W'(10'h100 + i));
        end
        #1;
        check_eq("full_after4", bif.ras_full, 1'b1);
        check_eq("err_before_ovf", bif.ras_err, 1'b0);
        bif.call_instr = 1'b1;
        bif.pc_next    = 10'h2aa;
        #1;
        check_eq("ovf_branch", bif.branch, 1'b1);
        tick();
        idle();
        #1;
        check_eq("ovf_err", bif.ras_err, 1'b1);
        check_eq("ovf_full", bif.ras_full, 1'b1);
        for (int i = RAS_DEPTH - 1; i >= 0; i--) begin
            bif.ret_instr = 1'b1;
            #1;
            check_eq($sformatf("drain_addr%0d", i), bif.address, 32'(10'h100 + i));
            tick();
        end
        #1;
        check_eq("drain_empty", bif.ras_empty, 1'b1);
        check_eq("unf_branch", bif.branch, 1'b0);
        check_eq("unf_addr", bif.address, 10'd0);
        tick();
        idle();
        #1;
        check_eq("unf_err_sticky", bif.ras_err, 1'b1);

        // 6: async reset between edges clears count, err and flags
        do_reset();
        load_flags(4'b0001);
        bif.ret_instr = 1'b1;
        tick();
        idle();
        call(10'h055);
        call(10'h066);
        #1;
        check_eq("pre_rst_err", bif.ras_err, 1'b1);
        check_eq("pre_rst_empty", bif.ras_empty, 1'b0);
        bif.branch_instr = 1'b1;
        reset = 1'b1;
        #1;
        check_eq("async_empty", bif.ras_empty, 1'b1);
        check_eq("async_err", bif.ras_err, 1'b0);
        check_eq("async_flag", bif.branch, 1'b0);
        #1;
        reset = 1'b0;
        idle();
        bif.ret_instr = 1'b1;
        #1;
        check_eq("post_rst_ret", bif.branch, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
